// File: rtl/apb_pkg.sv
// apb_pkg: shared definitions for the APB memory slave.
//   state_t        - FSM state enum (IDLE, WAIT, READY) built on ST_* encodings
//   bytes_per_word - bytes in one DATA_W-bit word
//   addr_lsb       - number of PADDR low bits below the word index
package apb_pkg;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_WAIT  = 2'b01;
   localparam logic [1:0] ST_READY = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      WAIT  = ST_WAIT,
      READY = ST_READY
   } state_t;

   function automatic int unsigned bytes_per_word(input int unsigned data_w);
      return data_w / 8;
   endfunction

   function automatic int unsigned addr_lsb(input int unsigned data_w);
      return $clog2(data_w / 8);
   endfunction

endpackage

// File: rtl/apb_mem_array.sv
// apb_mem_array: DEPTH x DATA_W synchronous RAM, byte-lane write enables,
// registered read port.
//   clk, rst - clock, async active-high reset (read register only)
//   we       - per-byte write enables, waddr/wdata - write port
//   re       - load rdata from mem[raddr]; rclr - load rdata with zero
//   rdata    - registered read data, holds when neither re nor rclr
// Storage itself is never reset.
module apb_mem_array
   import apb_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 1024,
   parameter int unsigned AW     = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DATA_W/8-1:0] we,
   input  logic [AW-1:0]       waddr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic                re,
   input  logic                rclr,
   input  logic [AW-1:0]       raddr,
   output logic [DATA_W-1:0]   rdata
);

   localparam int unsigned NB = bytes_per_word(DATA_W);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NB; i++) begin
         if (we[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       rdata <= '0;
      else if (rclr) rdata <= '0;
      else if (re)   rdata <= mem[raddr];
   end

endmodule

// File: rtl/apb_mem_slave.sv
// apb_mem_slave: APB memory slave with configurable wait states.
//   PCLK, PRESET           - clock, async active-high reset
//   PSEL, PENABLE, PWRITE  - APB control
//   PADDR, PWDATA, PSTRB   - byte address, write data, byte-lane enables
//   PRDATA, PREADY, PSLVERR- read data, completion, error response
// Optional macro APB_SLVERR_EN: drive PSLVERR for out-of-range accesses;
// otherwise PSLVERR is tied low and such accesses complete silently.
module apb_mem_slave
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic                PCLK,
   input  logic                PRESET,
   input  logic                PSEL,
   input  logic                PENABLE,
   input  logic                PWRITE,
   input  logic [ADDR_W-1:0]   PADDR,
   input  logic [DATA_W-1:0]   PWDATA,
   input  logic [DATA_W/8-1:0] PSTRB,
   output logic [DATA_W-1:0]   PRDATA,
   output logic                PREADY,
   output logic                PSLVERR
);

   localparam int unsigned LSB   = addr_lsb(DATA_W);
   localparam int unsigned NB    = bytes_per_word(DATA_W);
   localparam int unsigned IDX_W = ADDR_W - LSB;
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W-1:0] DEPTH_I = IDX_W'(DEPTH);

   state_t            state, next_state;
   logic [3:0]        wcnt, wcnt_next;
   logic [IDX_W-1:0]  idx_q;
   logic              write_q;
   logic [DATA_W-1:0] wdata_q;
   logic [NB-1:0]     strb_q;
   logic              pready_q;
   logic              latch;
   logic [NB-1:0]     mem_we;

   logic [IDX_W-1:0]  idx_in, cur_idx;
   logic              cur_write, cur_oor, oor_q;
   logic              enter_ready, rd_en, rd_clr;

   assign idx_in = PADDR[ADDR_W-1:LSB];

   if (LSB > 0) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^PADDR[LSB-1:0];
   end

   // With no wait states READY is entered straight from the setup edge,
   // before the request is latched, so the read/range check must look at
   // the live bus in IDLE and at the latched copy otherwise.
   assign cur_idx   = (state == IDLE) ? idx_in : idx_q;
   assign cur_write = (state == IDLE) ? PWRITE : write_q;
   assign cur_oor   = (cur_idx >= DEPTH_I);
   assign oor_q     = (idx_q >= DEPTH_I);

   always_comb begin
      next_state = state;
      wcnt_next  = wcnt;
      latch      = 1'b0;
      mem_we     = '0;
      case (state)
         IDLE: begin
            if (PSEL && !PENABLE) begin
               latch      = 1'b1;
               wcnt_next  = 4'(WAIT_CYCLES);
               next_state = (WAIT_CYCLES == 0) ? READY : WAIT;
            end
         end
         WAIT: begin
            if (!PSEL) begin
               next_state = IDLE;
               wcnt_next  = '0;
            end else begin
               wcnt_next = wcnt - 4'd1;
               if (wcnt == 4'd1) next_state = READY;
            end
         end
         READY: begin
            next_state = IDLE;
            if (PSEL && PENABLE && write_q && !oor_q) mem_we = strb_q;
         end
         default: next_state = IDLE;
      endcase
   end

   assign enter_ready = (next_state == READY) && (state != READY);
   assign rd_en       = enter_ready && !cur_write;
   assign rd_clr      = rd_en && cur_oor;

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state    <= IDLE;
         wcnt     <= '0;
         pready_q <= 1'b0;
         idx_q    <= '0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
         strb_q   <= '0;
      end else begin
         state    <= next_state;
         wcnt     <= wcnt_next;
         pready_q <= (next_state == READY);
         if (latch) begin
            idx_q   <= idx_in;
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
         end
      end
   end

   assign PREADY = pready_q;

`ifdef APB_SLVERR_EN
   logic pslverr_q;
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) pslverr_q <= 1'b0;
      else        pslverr_q <= (next_state == READY) && cur_oor;
   end
   assign PSLVERR = pslverr_q;
`else
   assign PSLVERR = 1'b0;
`endif

   apb_mem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_mem (
      .clk   (PCLK),
      .rst   (PRESET),
      .we    (mem_we),
      .waddr (idx_q[AW-1:0]),
      .wdata (wdata_q),
      .re    (rd_en),
      .rclr  (rd_clr),
      .raddr (cur_idx[AW-1:0]),
      .rdata (PRDATA)
   );

endmodule

// File: tb/tb_apb_mem_slave.sv
// tb_apb_mem_slave: self-checking bench for apb_mem_slave.
// Three instances on a shared APB bus (WAIT_CYCLES 0, 3, 4), selected by
// their own PSEL. Read expectations go through a scoreboard queue.
module tb_apb_mem_slave;
   import apb_pkg::*;

`ifdef APB_SLVERR_EN
   localparam logic SLV = 1'b1;
`else
   localparam logic SLV = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [2:0]       psel = '0;
   logic             penable = 1'b0;
   logic             pwrite = 1'b0;
   logic [31:0]      paddr = '0;
   logic [31:0]      pwdata = '0;
   logic [3:0]       pstrb = '0;
   logic [2:0][31:0] prdata;
   logic [2:0]       pready;
   logic [2:0]       pslverr;

   int unsigned n_pass = 0;
   int unsigned n_total = 0;
   logic [31:0] sb [$];

   always #5 clk = ~clk;

   apb_mem_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
      .PCLK(clk), .PRESET(rst), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
      .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

   apb_mem_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(1024), .WAIT_CYCLES(3)) dut1 (
      .PCLK(clk), .PRESET(rst), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
      .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

   apb_mem_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(1024), .WAIT_CYCLES(4)) dut2 (
      .PCLK(clk), .PRESET(rst), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
      .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp;
      logic        err;
   } vec_t;

   vec_t tbl [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // One complete APB transfer on instance sel. Starts at the next falling
   // edge so consecutive calls produce back-to-back transfers.
   task automatic xfer(input int unsigned sel, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input int unsigned exp_cyc, input string name);
      int unsigned cyc;
      @(negedge clk);
      psel    = 3'b001 << sel;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = data;
      pstrb   = strb;
      if (!wr) sb.push_back(exp_rd);
      cyc = 1;
      @(negedge clk);
      penable = 1'b1;
      cyc = 2;
      while (!pready[sel] && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check({name, " ready"}, 32'(pready[sel]), 32'd1);
      check({name, " cycles"}, cyc, exp_cyc);
      check({name, " err"}, 32'(pslverr[sel]), 32'(exp_err));
      if (!wr) check({name, " rdata"}, prdata[sel], sb.pop_front());
   endtask

   task automatic idle();
      @(negedge clk);
      psel    = '0;
      penable = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl.push_back('{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h0,        1'b0});
      tbl.push_back('{1'b0, 32'h10,       32'h0,        4'hF, 32'hDEADBEEF, 1'b0});
      tbl.push_back('{1'b1, 32'h20,       32'hFFFFFFFF, 4'hF, 32'h0,        1'b0});
      tbl.push_back('{1'b1, 32'h20,       32'h00000000, 4'h5, 32'h0,        1'b0});
      tbl.push_back('{1'b0, 32'h20,       32'h0,        4'h0, 32'hFF00FF00, 1'b0});
      tbl.push_back('{1'b1, 32'h24,       32'h11223344, 4'hF, 32'h0,        1'b0});
      tbl.push_back('{1'b1, 32'h24,       32'hA5A5A5A5, 4'h0, 32'h0,        1'b0});
      tbl.push_back('{1'b0, 32'h24,       32'h0,        4'hF, 32'h11223344, 1'b0});
      tbl.push_back('{1'b1, 32'h14,       32'h00000000, 4'hF, 32'h0,        1'b0});
      tbl.push_back('{1'b1, 32'h17,       32'hCAFEF00D, 4'h3, 32'h0,        1'b0});
      tbl.push_back('{1'b0, 32'h15,       32'h0,        4'h0, 32'h0000F00D, 1'b0});
      tbl.push_back('{1'b1, 32'h0,        32'h01020304, 4'hF, 32'h0,        1'b0});
      tbl.push_back('{1'b1, 32'h1000,     32'hFFFFFFFF, 4'hF, 32'h0,        SLV});
      tbl.push_back('{1'b0, 32'h1000,     32'h0,        4'hF, 32'h0,        SLV});
      tbl.push_back('{1'b0, 32'h0,        32'h0,        4'h0, 32'h01020304, 1'b0});
      tbl.push_back('{1'b0, 32'hFFFFFFFC, 32'h0,        4'h0, 32'h0,        SLV});

      // reset state
      repeat (2) @(negedge clk);
      for (int unsigned k = 0; k < 3; k += 2) begin
         check($sformatf("reset pready%0d", k), 32'(pready[k]), 32'd0);
         check($sformatf("reset pslverr%0d", k), 32'(pslverr[k]), 32'd0);
         check($sformatf("reset prdata%0d", k), prdata[k], 32'd0);
      end
      check("reset state0", 32'(dut0.state), 32'(IDLE));
      rst = 1'b0;

      // table-driven vectors on the zero-wait instance
      foreach (tbl[i])
         xfer(0, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].strb,
              tbl[i].exp, tbl[i].err, 2, $sformatf("vec%0d", i));
      idle();

      // READY with PSEL dropped: no write
      xfer(0, 1'b1, 32'h50, 32'h77777777, 4'hF, 32'h0, 1'b0, 2, "rdy pre");
      @(negedge clk);
      psel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 32'h50;
      pwdata = 32'h88888888; pstrb = 4'hF;
      @(negedge clk);
      psel = '0;
      @(negedge clk);
      xfer(0, 1'b0, 32'h50, 32'h0, 4'h0, 32'h77777777, 1'b0, 2, "rdy drop read");
      idle();

      // wait states: 3
      xfer(1, 1'b1, 32'h10, 32'h55AA55AA, 4'hF, 32'h0, 1'b0, 5, "wc3 wr");
      xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, 32'h55AA55AA, 1'b0, 5, "wc3 rd");
      xfer(1, 1'b1, 32'h40, 32'h11111111, 4'hF, 32'h0, 1'b0, 5, "wc3 pre");
      // abort in WAIT by dropping PSEL
      @(negedge clk);
      psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 32'h40;
      pwdata = 32'h22222222; pstrb = 4'hF;
      @(negedge clk);
      penable = 1'b1;
      @(negedge clk);
      psel = '0; penable = 1'b0;
      @(negedge clk);
      check("abort state", 32'(dut1.state), 32'(IDLE));
      repeat (4) begin
         @(negedge clk);
         check("abort pready", 32'(pready[1]), 32'd0);
      end
      xfer(1, 1'b0, 32'h40, 32'h0, 4'h0, 32'h11111111, 1'b0, 5, "abort read");
      idle();

      // reset mid-transfer on the 4-wait instance
      xfer(2, 1'b1, 32'h30, 32'h0BADF00D, 4'hF, 32'h0, 1'b0, 6, "wc4 pre wr");
      xfer(2, 1'b0, 32'h30, 32'h0, 4'h0, 32'h0BADF00D, 1'b0, 6, "wc4 pre rd");
      @(negedge clk);
      psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h30;
      pwdata = 32'h12345678; pstrb = 4'hF;
      @(negedge clk);
      penable = 1'b1;
      @(negedge clk);
      check("wc4 in wait", 32'(dut2.state), 32'(WAIT));
      rst = 1'b1;
      #1;
      check("rst pready", 32'(pready[2]), 32'd0);
      check("rst state", 32'(dut2.state), 32'(IDLE));
      check("rst prdata", prdata[2], 32'd0);
      @(negedge clk);
      psel = '0; penable = 1'b0; rst = 1'b0;
      xfer(2, 1'b0, 32'h30, 32'h0, 4'h0, 32'h0BADF00D, 1'b0, 6, "wc4 post rst rd");
      idle();

      // back-to-back
      for (int unsigned i = 0; i < 8; i++)
         xfer(0, 1'b1, 32'h100 + 4*i, 32'hA0000000 ^ (i * 32'h01010101), 4'hF,
              32'h0, 1'b0, 2, $sformatf("b2b wr%0d", i));
      for (int unsigned i = 0; i < 8; i++)
         xfer(0, 1'b0, 32'h100 + 4*i, 32'h0, 4'h0, 32'hA0000000 ^ (i * 32'h01010101),
              1'b0, 2, $sformatf("b2b rd%0d", i));
      idle();
      check("sb empty", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/apb_mem_slave.md
APB_MEM_SLAVE -- requirements
Module: apb_mem_slave

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning PADDR width in bits.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning data width in bits; legal values 8, 16, 32, 64.
REQ-003 The block SHALL have parameter DEPTH, default 1024, meaning the number of DATA_W-bit words of storage.
REQ-004 The block SHALL have parameter WAIT_CYCLES, default 0, meaning PREADY-low cycles inserted per access; legal range 0..15.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset: PCLK and PRESET.
REQ-006 The block SHALL have these ports:
- PCLK  in  1  clock
- PRESET  in  1  async active-high reset
- PSEL  in  1  slave select
- PENABLE  in  1  access phase
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  ADDR_W  byte address
- PWDATA  in  DATA_W  write data
- PSTRB  in  DATA_W/8  write byte-lane enables
- PRDATA  out  DATA_W  read data
- PREADY  out  1  transfer complete
- PSLVERR  out  1  error response

Function
REQ-007 The word index SHALL be PADDR[ADDR_W-1:log2(DATA_W/8)]; the low address bits are ignored.
REQ-008 The FSM SHALL have three states: IDLE, WAIT and READY.
REQ-009 In IDLE, when PSEL=1 and PENABLE=0, the block SHALL latch PADDR, PWRITE, PWDATA and PSTRB, load wcnt with WAIT_CYCLES, and go to READY if WAIT_CYCLES=0, else to WAIT.
REQ-010 In WAIT, wcnt SHALL decrement each cycle, and the FSM SHALL go to READY on the edge where wcnt=1.
REQ-011 In WAIT, if PSEL=0, the FSM SHALL go to IDLE with no memory update (abort).
REQ-012 PREADY SHALL be registered and equal 1 only in READY.
REQ-013 PRDATA SHALL load mem[index] on the edge entering READY for a read; otherwise it SHALL hold its value.
REQ-014 In READY, when PSEL=1 and PENABLE=1, a write SHALL update only the byte lanes with PSTRB[i]=1, and the FSM SHALL go to IDLE; PSTRB=0 on a write is a legal no-op.
REQ-015 Transfer timing SHALL be: WAIT_CYCLES=0 gives 2 cycles (setup plus one access cycle); in general 2+WAIT_CYCLES cycles.
REQ-016 Back-to-back transfers SHALL run with no bubble: the next setup phase is accepted in IDLE on the cycle following completion.
REQ-017 An out-of-range index (index >= DEPTH) SHALL never modify memory, and a read of it SHALL return all zeros.
REQ-018 PSTRB SHALL be ignored on reads.
REQ-019 In READY, if PSEL=0 or PENABLE=0, the FSM SHALL return to IDLE with no write.

Reset
REQ-020 While PRESET=1, the block SHALL asynchronously force state=IDLE, wcnt=0, PREADY=0, PSLVERR=0 and PRDATA=0.
REQ-021 Reset asserted mid-transfer SHALL abort the transfer with no memory write.
REQ-022 Memory contents SHALL NOT be reset.
REQ-023 After PRESET deasserts, the first setup phase SHALL be accepted on the next PCLK edge.

Configuration
REQ-024 With macro APB_SLVERR_EN defined, PSLVERR SHALL assert together with PREADY (in READY only) when the latched index >= DEPTH, and deassert on leaving READY.
REQ-025 Without APB_SLVERR_EN, PSLVERR SHALL be tied to 0, and out-of-range accesses SHALL complete silently per REQ-017.

Structure
REQ-026 Package apb_pkg SHALL hold the FSM state enum (IDLE, WAIT, READY) and the 2'b encoding constants.
REQ-027 Package apb_pkg SHALL hold the function for bytes-per-word / address-LSB computation.
REQ-028 Sub-module apb_mem_array SHALL implement the DEPTH x DATA_W synchronous RAM with byte-lane write enables and a registered read port.
REQ-029 The FSM, wait counter and range check SHALL remain in apb_mem_slave.

Verification
REQ-030 The bench SHALL check basic write then read: WAIT_CYCLES=0, write 0xDEADBEEF to 0x10, read 0x10 -> PREADY high in the 2nd cycle of each transfer, PRDATA=0xDEADBEEF, PSLVERR=0.
REQ-031 The bench SHALL check wait states: WAIT_CYCLES=3, read 0x10 -> PREADY low for 3 access cycles and high on the 4th; total 5 cycles.
REQ-032 The bench SHALL check byte strobes: write 0xFFFFFFFF to 0x20, then 0x00000000 with PSTRB=4'b0101, read 0x20 -> 0xFF00FF00.
REQ-033 The bench SHALL check out-of-range access: DEPTH=1024, APB_SLVERR_EN defined, write to byte 0x1000 then read it -> PSLVERR=1 with PREADY, PRDATA=0, and word 0 unchanged; without the macro, PSLVERR stays 0.
REQ-034 The bench SHALL check reset mid-transfer: WAIT_CYCLES=4, write 0x12345678 to 0x30, assert PRESET in the 2nd WAIT cycle -> PREADY=0 and state IDLE immediately; a later read of 0x30 returns its prior value.
REQ-035 The bench SHALL check back-to-back traffic: 8 consecutive writes with no idle, then 8 reads -> every transfer 2 cycles and all data matches.
